// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector of a small
// combinational block in binary or reflected-Gray order, holds each vector for
// HOLD cycles, samples the block's output at the end of the hold window and
// compares it against the EXPECT truth table.
module truth_table_sweeper #(
  parameter int unsigned             N_IN   = 3,
  parameter int unsigned             HOLD   = 10,
  parameter logic [(1<<N_IN)-1:0]    EXPECT = 8'hE8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            gray_mode,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            sample_valid,
  output logic            mismatch,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);

  localparam int unsigned N_VEC = 1 << N_IN;
  localparam int unsigned EW    = N_IN + 1;
  localparam int unsigned HCW   = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [N_IN-1:0] IDX_LAST  = N_IN'(N_VEC - 1);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic            mode_q, mode_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            sv_q, sv_d;
  logic            mm_q, mm_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [EW-1:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            ffv_q, ffv_d;

  logic            miss_c;
  logic [N_IN-1:0] idx_inc_c;

  // Maps the sweep index to the driven vector in the selected order.
  function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] i,
                                              input logic            gray);
    return gray ? (i ^ (i >> 1)) : i;
  endfunction

  // Next-state and registered-output logic for the sweep sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    mode_d    = mode_q;
    stim_d    = stim_q;
    busy_d    = busy_q;
    sv_d      = 1'b0;
    mm_d      = 1'b0;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ff_d      = ff_q;
    ffv_d     = ffv_q;
    miss_c    = (dut_out != EXPECT[stim_q]);
    idx_inc_c = idx_q + N_IN'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new sweep clears every result; done drops on the accepting edge.
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          hold_d  = '0;
          mode_d  = gray_mode;
          stim_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
        end
      end
      S_DRIVE: begin
        hold_d = hold_q + HCW'(1);
        if (hold_q == HOLD_LAST) begin
          sv_d = 1'b1;
          mm_d = miss_c;
          if (miss_c) begin
            err_d = err_q + EW'(1);
            if (!ffv_q) begin
              ff_d  = stim_q;
              ffv_d = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            // Last vector: stim keeps the final vector while results are held.
            state_d = S_DONE;
            hold_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d  = idx_inc_c;
            hold_d = '0;
            stim_d = map_vec(idx_inc_c, mode_q);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      mode_q  <= 1'b0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      sv_q    <= 1'b0;
      mm_q    <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      sv_q    <= sv_d;
      mm_q    <= mm_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign sample_valid     = sv_q;
  assign mismatch         = mm_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (HOLD=10 and HOLD=1) each
// driving a table-driven fake DUT; a reference model pushes expected samples
// and final results into queues that a negedge monitor pops and checks.
module tb_truth_table_sweeper;

  localparam logic [7:0] EXP = 8'hE8;

  typedef struct {
    int          inst;
    int unsigned cyc;
    logic [2:0]  vec;
    logic        mm;
  } smp_t;

  typedef struct {
    int          inst;
    int unsigned cyc;
    logic [3:0]  errs;
    logic [2:0]  ff;
    logic        ffv;
    logic        pass;
  } res_t;

  logic        clk;
  logic        rst   [2];
  logic        start [2];
  logic        gray  [2];
  logic [7:0]  tbl   [2];
  logic        dout  [2];
  logic [2:0]  stim  [2];
  logic        busy  [2];
  logic        sv    [2];
  logic        mm    [2];
  logic        done  [2];
  logic        pass  [2];
  logic [3:0]  errc  [2];
  logic [2:0]  ff    [2];
  logic        ffv   [2];

  logic [2:0]  last_stim [2];
  logic        done_prev [2];

  smp_t        smp_q[$];
  res_t        res_q[$];
  int unsigned cyc;
  int          total;
  int          bad;

  truth_table_sweeper #(.N_IN(3), .HOLD(10), .EXPECT(EXP)) u_a (
    .clk(clk), .reset(rst[0]), .start(start[0]), .gray_mode(gray[0]),
    .dut_out(dout[0]), .stim(stim[0]), .busy(busy[0]), .sample_valid(sv[0]),
    .mismatch(mm[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .first_fail(ff[0]), .first_fail_valid(ffv[0])
  );

  truth_table_sweeper #(.N_IN(3), .HOLD(1), .EXPECT(EXP)) u_b (
    .clk(clk), .reset(rst[1]), .start(start[1]), .gray_mode(gray[1]),
    .dut_out(dout[1]), .stim(stim[1]), .busy(busy[1]), .sample_valid(sv[1]),
    .mismatch(mm[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .first_fail(ff[1]), .first_fail_valid(ffv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Fake combinational DUTs: output is a lookup into the chosen table.
  always_comb begin
    for (int g = 0; g < 2; g++) dout[g] = tbl[g][stim[g]];
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int hold_of(input int g);
    return (g == 0) ? 10 : 1;
  endfunction

  // Reference model: expected sample stream and final result of one sweep.
  function automatic void expect_sweep(input int g, input int unsigned t0,
                                       input logic gm, input logic [7:0] t);
    int         errs;
    logic [2:0] first;
    logic       seen;
    errs  = 0;
    first = 3'd0;
    seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int   v;
      smp_t s;
      v      = gm ? (k ^ (k >> 1)) : k;
      s.inst = g;
      s.cyc  = t0 + 32'((k + 1) * hold_of(g));
      s.vec  = 3'(v);
      s.mm   = (EXP[v] != t[v]);
      smp_q.push_back(s);
      if (s.mm) begin
        errs++;
        if (!seen) begin
          first = 3'(v);
          seen  = 1'b1;
        end
      end
    end
    begin
      res_t r;
      r.inst = g;
      r.cyc  = t0 + 32'(8 * hold_of(g));
      r.errs = 4'(errs);
      r.ff   = first;
      r.ffv  = seen;
      r.pass = (errs == 0);
      res_q.push_back(r);
    end
  endfunction

  function automatic void flush(input int g);
    for (int i = smp_q.size() - 1; i >= 0; i--)
      if (smp_q[i].inst == g) smp_q.delete(i);
    for (int i = res_q.size() - 1; i >= 0; i--)
      if (res_q[i].inst == g) res_q.delete(i);
  endfunction

  // Monitor: checks every sample pulse and every rising done against the queues.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int idx;
      if (sv[g] === 1'b1) begin
        idx = -1;
        for (int i = 0; i < smp_q.size(); i++)
          if (idx < 0 && smp_q[i].inst == g) idx = i;
        if (idx < 0) begin
          chk($sformatf("i%0d_unexpected_sample", g), 1, 0);
        end else begin
          chk($sformatf("i%0d_smp_cycle", g), cyc, smp_q[idx].cyc);
          chk($sformatf("i%0d_smp_vec", g), 32'(last_stim[g]), 32'(smp_q[idx].vec));
          chk($sformatf("i%0d_smp_mismatch", g), 32'(mm[g]), 32'(smp_q[idx].mm));
          smp_q.delete(idx);
        end
      end else if (mm[g] !== 1'b0) begin
        chk($sformatf("i%0d_mismatch_without_sample", g), 32'(mm[g]), 0);
      end
      if (done[g] === 1'b1 && done_prev[g] !== 1'b1) begin
        idx = -1;
        for (int i = 0; i < res_q.size(); i++)
          if (idx < 0 && res_q[i].inst == g) idx = i;
        if (idx < 0) begin
          chk($sformatf("i%0d_unexpected_done", g), 1, 0);
        end else begin
          chk($sformatf("i%0d_done_cycle", g), cyc, res_q[idx].cyc);
          chk($sformatf("i%0d_err_count", g), 32'(errc[g]), 32'(res_q[idx].errs));
          chk($sformatf("i%0d_first_fail", g), 32'(ff[g]), 32'(res_q[idx].ff));
          chk($sformatf("i%0d_first_fail_valid", g), 32'(ffv[g]), 32'(res_q[idx].ffv));
          chk($sformatf("i%0d_pass", g), 32'(pass[g]), 32'(res_q[idx].pass));
          chk($sformatf("i%0d_busy_at_done", g), 32'(busy[g]), 0);
          res_q.delete(idx);
        end
      end
      last_stim[g] = stim[g];
      done_prev[g] = done[g];
    end
  end

  task automatic check_cleared(input int g, input string tag);
    chk($sformatf("i%0d_%s_stim", g, tag), 32'(stim[g]), 0);
    chk($sformatf("i%0d_%s_busy", g, tag), 32'(busy[g]), 0);
    chk($sformatf("i%0d_%s_sample_valid", g, tag), 32'(sv[g]), 0);
    chk($sformatf("i%0d_%s_done", g, tag), 32'(done[g]), 0);
    chk($sformatf("i%0d_%s_pass", g, tag), 32'(pass[g]), 0);
    chk($sformatf("i%0d_%s_err_count", g, tag), 32'(errc[g]), 0);
    chk($sformatf("i%0d_%s_first_fail", g, tag), 32'(ff[g]), 0);
    chk($sformatf("i%0d_%s_first_fail_valid", g, tag), 32'(ffv[g]), 0);
  endtask

  // Issues an accepted start at the next edge; returns at the following negedge.
  task automatic launch(input int g, input logic gm, input logic [7:0] t,
                        output int unsigned t0);
    tbl[g]   = t;
    gray[g]  = gm;
    start[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[g] = 1'b0;
    gray[g]  = 1'($urandom);
    t0       = cyc;
    expect_sweep(g, t0, gm, t);
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while (done[g] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done[g] !== 1'b1) chk($sformatf("i%0d_done_timeout", g), 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [7:0] majority_table();
    logic [7:0] t;
    for (int k = 0; k < 8; k++) t[k] = ($countones(3'(k)) >= 2);
    return t;
  endfunction

  initial begin
    int unsigned t0;
    total = 0;
    bad   = 0;
    for (int g = 0; g < 2; g++) begin
      rst[g]   = 1'b1;
      start[g] = 1'b0;
      gray[g]  = 1'b0;
      tbl[g]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) check_cleared(g, "reset");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Binary sweep against a correct majority block.
    launch(0, 1'b0, majority_table(), t0);
    wait_done(0);

    // Stuck-at-0 block, with a start pulse and gray change mid-sweep ignored.
    launch(0, 1'b0, 8'h00, t0);
    wait_until(t0 + 24);
    start[0] = 1'b1;
    gray[0]  = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);

    // Restart from DONE in Gray order: results clear on the accepting edge.
    launch(0, 1'b1, 8'h00, t0);
    chk("restart_done_dropped", 32'(done[0]), 0);
    chk("restart_stim_zero", 32'(stim[0]), 0);
    chk("restart_err_cleared", 32'(errc[0]), 0);
    chk("restart_ffv_cleared", 32'(ffv[0]), 0);
    chk("restart_busy", 32'(busy[0]), 1);
    wait_done(0);

    // HOLD=1 against a stuck-at-1 block.
    launch(1, 1'b0, 8'hFF, t0);
    wait_done(1);

    // Reset in the middle of a failing sweep discards everything.
    launch(0, 1'b0, 8'h00, t0);
    wait_until(t0 + 34);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    flush(0);
    check_cleared(0, "midreset");
    launch(0, 1'b1, majority_table(), t0);
    wait_done(0);

    // Reset and start on the same edge: reset wins.
    rst[0]   = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[0]   = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy[0]), 0);
    chk("rst_start_done", 32'(done[0]), 0);

    // Randomised truth tables and sweep orders on both instances.
    for (int r = 0; r < 6; r++) begin
      launch(0, 1'($urandom), 8'($urandom), t0);
      wait_done(0);
      launch(1, 1'($urandom), 8'($urandom), t0);
      wait_done(1);
    end

    repeat (3) @(negedge clk);
    chk("leftover_expectations", 32'(smp_q.size() + res_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
